// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared AXI4-Lite definitions for the memory responder: response codes,
// channel FSM state types and the default bus widths.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/axi_lite_mem_slave_bank.sv
// Word-organised RAM with one synchronous read port and one byte-enabled
// synchronous write port. A read and a write to the same word on the same
// edge return the old contents.
module mem_bank_byte_we
    import axi_lite_pkg::*;
#(
    parameter  int DATA_W = AXI_DATA_W,
    parameter  int DEPTH  = 4096,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [STRB_W-1:0] i_wr_strb
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Both ports share one process so that the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
        if (i_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder with independent read and write channels and
// programmable response latency. Out-of-window accesses answer DECERR.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W = AXI_ADDR_W,
    parameter int                DATA_W = AXI_DATA_W,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
    parameter int                RD_LAT = 2,
    parameter int                WR_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;
    // One extra bit so a window ending at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(8);
    localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_LAT - 1);

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // ---------------- read channel ----------------
    r_state_t          r_rstate, w_rnext;
    logic [3:0]        r_rcnt, w_rcnt_next;
    logic [IDX_W-1:0]  r_ar_idx;
    logic              r_ar_hit;
    logic              w_ar_hs;
    logic              w_rd_en;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_mem_q;

    assign arready = (r_rstate == R_IDLE) && !rst;
    assign w_ar_hs = arready && arvalid;

    // Read next-state: the RAM read fires on the cycle that precedes R_RESP.
    always_comb begin
        w_rnext     = r_rstate;
        w_rcnt_next = r_rcnt;
        w_rd_en     = 1'b0;
        w_rd_idx    = r_ar_idx;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    if (RD_LAT == 0) begin
                        w_rnext  = R_RESP;
                        w_rd_en  = 1'b1;
                        w_rd_idx = addr_idx(araddr);
                    end else begin
                        w_rnext     = R_WAIT;
                        w_rcnt_next = 4'd0;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == RD_LAST) begin
                    w_rnext = R_RESP;
                    w_rd_en = 1'b1;
                end else begin
                    w_rcnt_next = r_rcnt + 4'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    w_rnext = R_IDLE;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read state and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= 4'd0;
        end else begin
            r_rstate <= w_rnext;
            r_rcnt   <= w_rcnt_next;
        end
    end

    // Latch the decoded read address at the AR handshake.
    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_ar_idx <= addr_idx(araddr);
            r_ar_hit <= addr_hit(araddr);
        end
    end

    // RAM output only moves on entry to R_RESP, so rdata stays stable while stalled.
    assign rvalid = (r_rstate == R_RESP);
    assign rdata  = (rvalid && r_ar_hit) ? w_mem_q : '0;
    assign rresp  = (rvalid && !r_ar_hit) ? RESP_DECERR : RESP_OKAY;

    // ---------------- write channel ----------------
    w_state_t          r_wstate, w_wnext;
    logic [3:0]        r_wcnt, w_wcnt_next;
    logic              r_aw_got, r_w_got, w_aw_got_next, w_w_got_next;
    logic [IDX_W-1:0]  r_aw_idx;
    logic              r_aw_hit;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              w_aw_hs, w_w_hs;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_cmt_idx;
    logic              w_cmt_hit;
    logic [DATA_W-1:0] w_cmt_data;
    logic [STRB_W-1:0] w_cmt_strb;

    assign awready = (r_wstate == W_IDLE) && !r_aw_got && !rst;
    assign wready  = (r_wstate == W_IDLE) && !r_w_got && !rst;
    assign w_aw_hs = awready && awvalid;
    assign w_w_hs  = wready && wvalid;

    // With zero latency the commit happens on the capture edge, so bypass the latches.
    assign w_cmt_idx  = w_aw_hs ? addr_idx(awaddr) : r_aw_idx;
    assign w_cmt_hit  = w_aw_hs ? addr_hit(awaddr) : r_aw_hit;
    assign w_cmt_data = w_w_hs ? wdata : r_wdata;
    assign w_cmt_strb = w_w_hs ? wstrb : r_wstrb;

    // Write next-state: AW and W are collected in any order, then the commit is timed.
    always_comb begin
        w_wnext       = r_wstate;
        w_wcnt_next   = r_wcnt;
        w_aw_got_next = r_aw_got || w_aw_hs;
        w_w_got_next  = r_w_got || w_w_hs;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_got_next && w_w_got_next) begin
                    if (WR_LAT == 0) begin
                        w_wnext = W_RESP;
                        w_wr_en = w_cmt_hit;
                    end else begin
                        w_wnext     = W_WAIT;
                        w_wcnt_next = 4'd0;
                    end
                end
            end
            W_WAIT: begin
                if (r_wcnt == WR_LAST) begin
                    w_wnext = W_RESP;
                    w_wr_en = w_cmt_hit;
                end else begin
                    w_wcnt_next = r_wcnt + 4'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wnext       = W_IDLE;
                    w_aw_got_next = 1'b0;
                    w_w_got_next  = 1'b0;
                end
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Write state, latency counter and capture flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= 4'd0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            r_wcnt   <= w_wcnt_next;
            r_aw_got <= w_aw_got_next;
            r_w_got  <= w_w_got_next;
        end
    end

    // Hold the captured AW and W beats until the commit.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_aw_idx <= addr_idx(awaddr);
            r_aw_hit <= addr_hit(awaddr);
        end
        if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
        end
    end

    assign bvalid = (r_wstate == W_RESP);
    assign bresp  = (bvalid && !r_aw_hit) ? RESP_DECERR : RESP_OKAY;

    mem_bank_byte_we #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_mem_q),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_cmt_idx),
        .i_wr_data (w_cmt_data),
        .i_wr_strb (w_cmt_strb)
    );

endmodule
